// File: rtl/rcu_pll_ctrl_if.sv
// Control/status and PLL-side signals of the RCU PLL sequencer.
// The slave modport is the controller; master is the RCU/PLL side driving it.
interface rcu_pll_ctrl_if #(
  parameter int CFG_WIDTH = 3
);
  logic                 en_i;
  logic [CFG_WIDTH-1:0] cfg_i;
  logic                 cfg_wr_i;
  logic                 err_clr_i;
  logic                 pll_lock_i;
  logic                 pll_en_o;
  logic [CFG_WIDTH-1:0] clk_cfg_o;
  logic                 clk_sel_o;
  logic                 lock_o;
  logic                 busy_o;
  logic                 timeout_o;
  logic                 lock_lost_o;

  modport master (
    output en_i, cfg_i, cfg_wr_i, err_clr_i, pll_lock_i,
    input  pll_en_o, clk_cfg_o, clk_sel_o, lock_o, busy_o, timeout_o, lock_lost_o
  );

  modport slave (
    input  en_i, cfg_i, cfg_wr_i, err_clr_i, pll_lock_i,
    output pll_en_o, clk_cfg_o, clk_sel_o, lock_o, busy_o, timeout_o, lock_lost_o
  );
endinterface

// File: rtl/rcu_pll_ctrl.sv
// PLL sequencer: power-off, configure, enable, wait for lock, qualify lock,
// then select the PLL clock; falls back to the reference clock on timeout or lock loss.
module rcu_pll_ctrl #(
  parameter int CFG_WIDTH     = 3,
  parameter int OFF_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  rcu_pll_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int OFF_W = $clog2(OFF_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OFF_CYCLES - 1);
  localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(OFF_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OFF,
    S_WAIT,
    S_STAB,
    S_RUN,
    S_ERR
  } state_t;

  state_t state_q, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [STB_W-1:0]       stb_cnt;
  logic [OFF_W-1:0]       off_cnt;
  logic                   tmo_hit;
  logic                   cfg_load;
  logic                   enter_off;
  logic                   set_tmo;
  logic                   set_lost;

  logic                 pll_en_q;
  logic [CFG_WIDTH-1:0] clk_cfg_q;
  logic                 clk_sel_q;
  logic                 busy_q;
  logic                 timeout_q;
  logic                 lock_lost_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock_i};
  end

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign tmo_hit = (tmo_cnt >= TMO_LAST);

  // en_i low beats everything; within a state, timeout beats lock loss beats cfg_wr_i.
  always_comb begin
    state_nx  = state_q;
    cfg_load  = 1'b0;
    enter_off = 1'b0;
    set_tmo   = 1'b0;
    set_lost  = 1'b0;
    if (!bus.en_i) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_nx  = S_OFF;
          cfg_load  = 1'b1;
          enter_off = 1'b1;
        end
        S_OFF: begin
          if (bus.cfg_wr_i) begin
            cfg_load  = 1'b1;
            enter_off = 1'b1;
          end else if (off_cnt >= OFF_LAST) begin
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (tmo_hit && !lock_s) begin
            state_nx = S_ERR;
            set_tmo  = 1'b1;
          end else if (bus.cfg_wr_i) begin
            state_nx  = S_OFF;
            cfg_load  = 1'b1;
            enter_off = 1'b1;
          end else if (lock_s) begin
            state_nx = S_STAB;
          end
        end
        S_STAB: begin
          if (tmo_hit) begin
            state_nx = S_ERR;
            set_tmo  = 1'b1;
          end else if (bus.cfg_wr_i) begin
            state_nx  = S_OFF;
            cfg_load  = 1'b1;
            enter_off = 1'b1;
          end else if (!lock_s) begin
            state_nx = S_WAIT;
          end else if (stb_cnt >= STB_LAST) begin
            state_nx = S_RUN;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_nx  = S_OFF;
            enter_off = 1'b1;
            set_lost  = 1'b1;
          end else if (bus.cfg_wr_i) begin
            state_nx  = S_OFF;
            cfg_load  = 1'b1;
            enter_off = 1'b1;
          end
        end
        S_ERR:   state_nx = S_ERR;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  // tmo_cnt spans WAIT and STAB together, so a STAB->WAIT bounce does not extend the timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_cnt <= '0;
      tmo_cnt <= '0;
      stb_cnt <= '0;
    end else begin
      if (enter_off)
        off_cnt <= '0;
      else if (state_q == S_OFF && off_cnt < OFF_MAX)
        off_cnt <= off_cnt + OFF_W'(1);

      if (state_nx == S_IDLE || state_nx == S_OFF)
        tmo_cnt <= '0;
      else if ((state_q == S_WAIT || state_q == S_STAB) && tmo_cnt < TMO_MAX)
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state_nx != S_STAB || state_q != S_STAB)
        stb_cnt <= '0;
      else if (stb_cnt < STB_MAX)
        stb_cnt <= stb_cnt + STB_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pll_en_q    <= 1'b0;
      clk_cfg_q   <= '0;
      clk_sel_q   <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      pll_en_q  <= (state_nx == S_WAIT) || (state_nx == S_STAB) || (state_nx == S_RUN);
      clk_sel_q <= (state_nx == S_RUN);
      busy_q    <= (state_nx == S_OFF) || (state_nx == S_WAIT) || (state_nx == S_STAB);
      if (cfg_load)
        clk_cfg_q <= bus.cfg_i;
      timeout_q   <= set_tmo  | (timeout_q   & ~bus.err_clr_i);
      lock_lost_q <= set_lost | (lock_lost_q & ~bus.err_clr_i);
    end
  end

  assign bus.pll_en_o    = pll_en_q;
  assign bus.clk_cfg_o   = clk_cfg_q;
  assign bus.clk_sel_o   = clk_sel_q;
  assign bus.lock_o      = clk_sel_q;
  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_rcu_pll_ctrl.sv
// Directed bench for rcu_pll_ctrl with default parameters.
// Cycle n means just after the n-th rising edge counted from the start of each scenario.
module tb_rcu_pll_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rcu_pll_ctrl_if #(.CFG_WIDTH(3)) bus ();

  rcu_pll_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] cfg, input logic cfg_wr,
                               input logic err_clr, input logic lock);
    bus.en_i       = en;
    bus.cfg_i      = cfg;
    bus.cfg_wr_i   = cfg_wr;
    bus.err_clr_i  = err_clr;
    bus.pll_lock_i = lock;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    tickn(2);
    checkOutput("rst_pll_en", 32'(bus.pll_en_o), 0);
    checkOutput("rst_clk_sel", 32'(bus.clk_sel_o), 0);
    checkOutput("rst_lock", 32'(bus.lock_o), 0);
    checkOutput("rst_busy", 32'(bus.busy_o), 0);
    checkOutput("rst_cfg", 32'(bus.clk_cfg_o), 0);
    checkOutput("rst_tmo", 32'(bus.timeout_o), 0);
    checkOutput("rst_lost", 32'(bus.lock_lost_o), 0);
    rst = 1'b0;

    // nominal bring-up: lock rises at cycle 50, RUN at 69
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    tickn(1);
    checkOutput("up_cfg_c1", 32'(bus.clk_cfg_o), 5);
    checkOutput("up_busy_c1", 32'(bus.busy_o), 1);
    checkOutput("up_pll_en_c1", 32'(bus.pll_en_o), 0);
    tickn(7);
    checkOutput("up_pll_en_c8", 32'(bus.pll_en_o), 0);
    tickn(1);
    checkOutput("up_pll_en_c9", 32'(bus.pll_en_o), 1);
    tickn(41);
    bus.pll_lock_i = 1'b1;
    tickn(18);
    checkOutput("up_sel_c68", 32'(bus.clk_sel_o), 0);
    checkOutput("up_busy_c68", 32'(bus.busy_o), 1);
    tickn(1);
    checkOutput("up_sel_c69", 32'(bus.clk_sel_o), 1);
    checkOutput("up_lock_c69", 32'(bus.lock_o), 1);
    checkOutput("up_busy_c69", 32'(bus.busy_o), 0);

    // lock loss in RUN (lock drops at c), with err_clr colliding with the set
    tickn(5);
    bus.pll_lock_i = 1'b0;
    tickn(2);
    checkOutput("ll_sel_c2", 32'(bus.clk_sel_o), 1);
    bus.err_clr_i = 1'b1;
    tickn(1);
    bus.err_clr_i = 1'b0;
    checkOutput("ll_sel_c3", 32'(bus.clk_sel_o), 0);
    checkOutput("ll_lost_c3", 32'(bus.lock_lost_o), 1);
    checkOutput("ll_pll_en_c3", 32'(bus.pll_en_o), 0);
    checkOutput("ll_busy_c3", 32'(bus.busy_o), 1);
    tickn(2);
    bus.pll_lock_i = 1'b1;
    tickn(5);
    checkOutput("ll_pll_en_c10", 32'(bus.pll_en_o), 0);
    tickn(1);
    checkOutput("ll_pll_en_c11", 32'(bus.pll_en_o), 1);
    tickn(16);
    checkOutput("ll_sel_c27", 32'(bus.clk_sel_o), 0);
    tickn(1);
    checkOutput("ll_sel_c28", 32'(bus.clk_sel_o), 1);
    bus.err_clr_i = 1'b1;
    tickn(1);
    bus.err_clr_i = 1'b0;
    checkOutput("ll_lost_clr", 32'(bus.lock_lost_o), 0);

    // reconfigure from RUN
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 1'b1);
    tickn(1);
    bus.cfg_wr_i = 1'b0;
    checkOutput("wr_cfg_c1", 32'(bus.clk_cfg_o), 2);
    checkOutput("wr_sel_c1", 32'(bus.clk_sel_o), 0);
    checkOutput("wr_pll_en_c1", 32'(bus.pll_en_o), 0);
    tickn(7);
    checkOutput("wr_pll_en_c8", 32'(bus.pll_en_o), 0);
    tickn(1);
    checkOutput("wr_pll_en_c9", 32'(bus.pll_en_o), 1);
    tickn(16);
    checkOutput("wr_sel_c25", 32'(bus.clk_sel_o), 0);
    tickn(1);
    checkOutput("wr_sel_c26", 32'(bus.clk_sel_o), 1);

    // en_i low from RUN goes to IDLE without flagging lock loss
    applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    tickn(1);
    checkOutput("off_pll_en", 32'(bus.pll_en_o), 0);
    checkOutput("off_sel", 32'(bus.clk_sel_o), 0);
    checkOutput("off_lost", 32'(bus.lock_lost_o), 0);
    tickn(2);

    // en_i low and cfg_wr_i together in WAIT: IDLE, cfg held
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    tickn(9);
    checkOutput("wt_pll_en", 32'(bus.pll_en_o), 1);
    applyStimulus(1'b0, 3'b011, 1'b1, 1'b0, 1'b0);
    tickn(1);
    bus.cfg_wr_i = 1'b0;
    checkOutput("wt_idle_pll_en", 32'(bus.pll_en_o), 0);
    checkOutput("wt_idle_busy", 32'(bus.busy_o), 0);
    checkOutput("wt_idle_cfg", 32'(bus.clk_cfg_o), 5);
    tickn(2);
    checkOutput("wt_idle_busy2", 32'(bus.busy_o), 0);

    // lock never arrives: ERR at cycle 1033
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    tickn(1032);
    checkOutput("to_pll_en_c1032", 32'(bus.pll_en_o), 1);
    checkOutput("to_flag_c1032", 32'(bus.timeout_o), 0);
    tickn(1);
    checkOutput("to_pll_en_c1033", 32'(bus.pll_en_o), 0);
    checkOutput("to_flag_c1033", 32'(bus.timeout_o), 1);
    checkOutput("to_busy_c1033", 32'(bus.busy_o), 0);
    bus.err_clr_i = 1'b1;
    tickn(1);
    bus.err_clr_i = 1'b0;
    checkOutput("to_flag_clr", 32'(bus.timeout_o), 0);
    tickn(3);
    checkOutput("to_err_busy", 32'(bus.busy_o), 0);
    checkOutput("to_err_pll_en", 32'(bus.pll_en_o), 0);
    bus.en_i = 1'b0;
    tickn(1);
    bus.en_i = 1'b1;
    tickn(1);
    checkOutput("to_restart_busy", 32'(bus.busy_o), 1);
    bus.en_i = 1'b0;
    tickn(1);

    // lock drops in STAB after 10 high cycles, relocks in time
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    tickn(20);
    bus.pll_lock_i = 1'b1;
    tickn(11);
    bus.pll_lock_i = 1'b0;
    tickn(8);
    checkOutput("sb_sel_c39", 32'(bus.clk_sel_o), 0);
    checkOutput("sb_busy_c39", 32'(bus.busy_o), 1);
    tickn(1);
    bus.pll_lock_i = 1'b1;
    tickn(18);
    checkOutput("sb_sel_c58", 32'(bus.clk_sel_o), 0);
    tickn(1);
    checkOutput("sb_sel_c59", 32'(bus.clk_sel_o), 1);
    applyStimulus(1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
    tickn(3);

    // same bounce, relock too late: timeout in STAB at cycle 1033
    bus.en_i = 1'b1;
    tickn(20);
    bus.pll_lock_i = 1'b1;
    tickn(11);
    bus.pll_lock_i = 1'b0;
    tickn(989);
    bus.pll_lock_i = 1'b1;
    tickn(12);
    checkOutput("sl_pll_en_c1032", 32'(bus.pll_en_o), 1);
    checkOutput("sl_flag_c1032", 32'(bus.timeout_o), 0);
    tickn(1);
    checkOutput("sl_pll_en_c1033", 32'(bus.pll_en_o), 0);
    checkOutput("sl_flag_c1033", 32'(bus.timeout_o), 1);
    tickn(6);
    checkOutput("sl_sel_c1039", 32'(bus.clk_sel_o), 0);
    bus.en_i = 1'b0;
    tickn(1);
    checkOutput("sl_flag_idle", 32'(bus.timeout_o), 1);

    // reset pulse mid-STAB
    bus.en_i = 1'b1;
    tickn(15);
    checkOutput("rs_pll_en_pre", 32'(bus.pll_en_o), 1);
    rst = 1'b1;
    #2;
    checkOutput("rs_pll_en", 32'(bus.pll_en_o), 0);
    checkOutput("rs_busy", 32'(bus.busy_o), 0);
    checkOutput("rs_cfg", 32'(bus.clk_cfg_o), 0);
    checkOutput("rs_tmo", 32'(bus.timeout_o), 0);
    tickn(1);
    rst = 1'b0;
    tickn(1);
    checkOutput("rs_busy_c1", 32'(bus.busy_o), 1);
    checkOutput("rs_cfg_c1", 32'(bus.clk_cfg_o), 5);
    tickn(24);
    checkOutput("rs_sel_c25", 32'(bus.clk_sel_o), 0);
    tickn(1);
    checkOutput("rs_sel_c26", 32'(bus.clk_sel_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
